pin_entry: RTL and testbench
============================

PIN_ENTRY -- requirements
Module: pin_entry

Interface
REQ-001 SHALL have parameter PIN_LEN, default 4, number of PIN digits (1..8).
REQ-002 SHALL have parameter MAX_TRIES, default 3, consecutive failures before lockout.
REQ-003 SHALL have parameter LOCK_CYCLES, default 1000, lockout duration in clk cycles.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port key_valid  in  1  one-cycle pulse for a button press.
REQ-007 SHALL have port key_index  in  4  physical button position: 0..9 digit keys, 10 clear, 11 enter, 12..15 ignored.
REQ-008 SHALL have port button_index  out  4  position sent to the shuffled display register.
REQ-009 SHALL have port digit_in  in  4  digit shown at button_index, returned combinationally by the display register.
REQ-010 SHALL have port pw_load  in  1  pulse that stores pw_value as the password.
REQ-011 SHALL have port pw_value  in  4*PIN_LEN  new password, first digit in the MS nibble.
REQ-012 SHALL have port unlock  out  1  one-cycle pulse on a correct PIN.
REQ-013 SHALL have port fail  out  1  one-cycle pulse on an incorrect PIN.
REQ-014 SHALL have port locked  out  1  high during lockout.
REQ-015 SHALL have port digit_count  out  4  digits captured so far.
REQ-016 SHALL have port shuffle_init  out  1  one-cycle reshuffle request to the display register.

Function
REQ-017 SHALL drive button_index = key_index combinationally, and 0 when key_valid is low.
REQ-018 SHALL use FSM states IDLE, COLLECT, CHECK, LOCKOUT.
REQ-019 SHALL, in IDLE or COLLECT, on key_valid with key_index<10 and digit_count<PIN_LEN, shift digit_in into the LS nibble of the entry register, increment digit_count the same cycle, and enter COLLECT.
REQ-020 SHALL ignore digit keys when digit_count==PIN_LEN; the count and register stay unchanged.
REQ-021 SHALL, on key 10 (clear), zero the entry register and digit_count and return to IDLE.
REQ-022 SHALL, on key 11 (enter) in COLLECT, go to CHECK.
REQ-023 SHALL ignore key 11 in IDLE.
REQ-024 SHALL, in CHECK (one cycle), compare the entry against the password only when digit_count==PIN_LEN; a shorter entry counts as a mismatch.
REQ-025 SHALL, on a match, pulse unlock the cycle after CHECK, zero the try counter, clear the entry and return to IDLE.
REQ-026 SHALL, on a mismatch, pulse fail the cycle after CHECK, increment the try counter, clear the entry, and go to LOCKOUT when tries==MAX_TRIES, otherwise to IDLE.
REQ-027 SHALL, in LOCKOUT, hold locked=1, ignore all keys, count LOCK_CYCLES cycles, then zero the try counter and go to IDLE.
REQ-028 SHALL, in CHECK and LOCKOUT, ignore key_valid entirely.
REQ-029 SHALL, on pw_load, store pw_value, clear the entry and digit_count, and return to IDLE unless in LOCKOUT.
REQ-030 SHALL, in LOCKOUT, apply a pw_load password update but stay locked.
REQ-031 SHALL give pw_load priority over key_valid in the same cycle.

Reset
REQ-032 SHALL, on rst high at a clk edge, set state IDLE, entry and password 0, digit_count 0, try and lockout counters 0, and unlock, fail, locked and shuffle_init to 0.
REQ-033 SHALL abort any entry, check or lockout in progress on rst.

Configuration
REQ-034 SHALL use macro PIN_SHUFFLE_EN: when defined, pulse shuffle_init for one cycle together with every unlock or fail pulse and once on the first cycle after reset; when undefined, tie shuffle_init to 0.

Structure
REQ-035 SHALL place the state enum, KEY_CLEAR=10 and KEY_ENTER=11 in shared package pin_entry_pkg.
REQ-036 SHALL implement the lockout countdown in sub-module lockout_timer (start pulse in, busy out).

Verification
REQ-037 SHALL cover: password 1234 loaded, identity display mapping, keys 1,2,3,4,enter -> unlock pulse exactly 2 cycles after the enter pulse; fail stays 0.
REQ-038 SHALL cover: display mapping position 0 shows 7, key 0 pressed -> entry LS nibble = 7 and digit_count = 1 the next cycle.
REQ-039 SHALL cover: keys 1,2,enter -> fail pulse and digit_count back to 0; then keys 1,2,3,4,5,enter -> 5th digit ignored and unlock.
REQ-040 SHALL cover: three wrong PINs with LOCK_CYCLES=10 -> locked=1 for exactly 10 cycles, keys ignored, and a correct PIN afterwards -> unlock.
REQ-041 SHALL cover: rst asserted after 2 digits -> digit_count=0 and state IDLE; with PIN_SHUFFLE_EN defined, shuffle_init pulses after reset and with each unlock or fail.

Source files
------------

// File: rtl/pin_entry_pkg.sv
// Shared types and key codes for the PIN entry controller.
package pin_entry_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    CHECK   = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  localparam logic [3:0] KEY_CLEAR = 4'd10;
  localparam logic [3:0] KEY_ENTER = 4'd11;

  function automatic logic is_digit(input logic [3:0] key);
    return key < 4'd10;
  endfunction

endpackage

// File: rtl/pin_entry_lockout_timer.sv
// Lockout countdown: a start pulse begins a LOCK_CYCLES-long lockout window.
module lockout_timer #(
  parameter int unsigned LOCK_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy
);

  localparam int unsigned CW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  logic [CW-1:0] cnt;

  // busy drops on the final lockout cycle so the owner leaves exactly on time
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= CW'(LOCK_CYCLES - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/pin_entry.sv
// PIN entry controller with shuffled keypad, try counting and timed lockout.
// Optional feature macro: PIN_SHUFFLE_EN (drives shuffle_init reshuffle requests).
module pin_entry
  import pin_entry_pkg::*;
#(
  parameter int unsigned PIN_LEN     = 4,
  parameter int unsigned MAX_TRIES   = 3,
  parameter int unsigned LOCK_CYCLES = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_valid,
  input  logic [3:0]           key_index,
  output logic [3:0]           button_index,
  input  logic [3:0]           digit_in,
  input  logic                 pw_load,
  input  logic [4*PIN_LEN-1:0] pw_value,
  output logic                 unlock,
  output logic                 fail,
  output logic                 locked,
  output logic [3:0]           digit_count,
  output logic                 shuffle_init
);

  localparam int unsigned EW = 4 * PIN_LEN;
  localparam int unsigned TW = $clog2(MAX_TRIES + 1);

  state_t        state, state_next;
  logic [EW-1:0] entry, entry_next, password;
  logic [EW+3:0] shifted;
  logic [3:0]    count, count_next;
  logic [TW-1:0] tries, tries_next, tries_inc;
  logic          unlock_q, fail_q, unlock_next, fail_next;
  logic          match, timer_start, timer_busy;

  lockout_timer #(.LOCK_CYCLES(LOCK_CYCLES)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .start(timer_start),
    .busy (timer_busy)
  );

  always_comb begin
    state_next  = state;
    entry_next  = entry;
    count_next  = count;
    tries_next  = tries;
    unlock_next = 1'b0;
    fail_next   = 1'b0;
    timer_start = 1'b0;
    shifted     = {entry, digit_in};
    tries_inc   = tries + TW'(1);
    match       = (count == 4'(PIN_LEN)) && (entry == password);

    if (pw_load) begin
      entry_next = '0;
      count_next = '0;
      if (state != LOCKOUT) state_next = IDLE;
    end else begin
      case (state)
        IDLE, COLLECT: begin
          if (key_valid) begin
            if (is_digit(key_index)) begin
              if (count < 4'(PIN_LEN)) begin
                entry_next = shifted[EW-1:0];
                count_next = count + 4'd1;
                state_next = COLLECT;
              end
            end else if (key_index == KEY_CLEAR) begin
              entry_next = '0;
              count_next = '0;
              state_next = IDLE;
            end else if (key_index == KEY_ENTER && state == COLLECT) begin
              state_next = CHECK;
            end
          end
        end
        CHECK: begin
          entry_next = '0;
          count_next = '0;
          if (match) begin
            unlock_next = 1'b1;
            tries_next  = '0;
            state_next  = IDLE;
          end else begin
            fail_next  = 1'b1;
            tries_next = tries_inc;
            if (tries_inc == TW'(MAX_TRIES)) begin
              state_next  = LOCKOUT;
              timer_start = 1'b1;
            end else begin
              state_next = IDLE;
            end
          end
        end
        LOCKOUT: begin
          if (!timer_busy) begin
            tries_next = '0;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      entry    <= '0;
      password <= '0;
      count    <= '0;
      tries    <= '0;
      unlock_q <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      state    <= state_next;
      entry    <= entry_next;
      count    <= count_next;
      tries    <= tries_next;
      unlock_q <= unlock_next;
      fail_q   <= fail_next;
      if (pw_load) password <= pw_value;
    end
  end

  assign button_index = key_valid ? key_index : 4'd0;
  assign unlock       = unlock_q;
  assign fail         = fail_q;
  assign locked       = (state == LOCKOUT);
  assign digit_count  = count;

`ifdef PIN_SHUFFLE_EN
  logic boot_q, shuffle_q;

  // boot_q marks the first cycle after reset; masked while rst is still held
  always_ff @(posedge clk) begin
    if (rst) begin
      boot_q    <= 1'b1;
      shuffle_q <= 1'b0;
    end else begin
      boot_q    <= 1'b0;
      shuffle_q <= unlock_next | fail_next;
    end
  end

  assign shuffle_init = shuffle_q | (boot_q & ~rst);
`else
  assign shuffle_init = 1'b0;
`endif

endmodule

// File: tb/tb_pin_entry.sv
// Directed, table-driven bench for pin_entry (PIN_LEN=4, MAX_TRIES=3, LOCK_CYCLES=10).
module tb_pin_entry;
  import pin_entry_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_index = 4'd0;
  logic [3:0]  button_index;
  logic [3:0]  digit_in;
  logic        pw_load = 1'b0;
  logic [15:0] pw_value = 16'h0;
  logic        unlock, fail, locked, shuffle_init;
  logic [3:0]  digit_count;

  logic [3:0]  dmap [16];
  int errors = 0;
  int checks = 0;

  pin_entry #(.PIN_LEN(4), .MAX_TRIES(3), .LOCK_CYCLES(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_valid   (key_valid),
    .key_index   (key_index),
    .button_index(button_index),
    .digit_in    (digit_in),
    .pw_load     (pw_load),
    .pw_value    (pw_value),
    .unlock      (unlock),
    .fail        (fail),
    .locked      (locked),
    .digit_count (digit_count),
    .shuffle_init(shuffle_init)
  );

  always #5 clk = ~clk;
  always_comb digit_in = dmap[button_index];

  typedef struct {
    logic        kv;
    logic [3:0]  key;
    logic        ld;
    logic [15:0] pw;
    logic [3:0]  cnt;
    logic        u;
    logic        f;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic kv, logic [3:0] key, logic ld, logic [15:0] pw,
                              logic [3:0] cnt, logic u, logic f);
    vec_t v;
    v.kv = kv; v.key = key; v.ld = ld; v.pw = pw; v.cnt = cnt; v.u = u; v.f = f;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_index = k;
    @(posedge clk); #1;
    key_valid = 1'b0;
    key_index = 4'd0;
  endtask

  task automatic enter_pin(input logic [15:0] pin);
    logic [15:0] p;
    p = pin;
    for (int unsigned i = 0; i < 4; i++) begin
      press(p[15:12]);
      p = p << 4;
    end
    press(KEY_ENTER);
  endtask

  logic exp_sh;
  int   n;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) dmap[i] = 4'(i);

    // table: {key_valid, key, pw_load, pw_value} -> {digit_count, unlock, fail}
    vecs.push_back(mk(0, 0,  1, 16'h1234, 0, 0, 0));
    vecs.push_back(mk(1, 1,  0, 16'h0,    1, 0, 0));
    vecs.push_back(mk(1, 2,  0, 16'h0,    2, 0, 0));
    vecs.push_back(mk(1, 3,  0, 16'h0,    3, 0, 0));
    vecs.push_back(mk(1, 4,  0, 16'h0,    4, 0, 0));
    vecs.push_back(mk(1, 11, 0, 16'h0,    4, 0, 0));
    vecs.push_back(mk(0, 0,  0, 16'h0,    0, 1, 0));
    vecs.push_back(mk(0, 0,  0, 16'h0,    0, 0, 0));
    vecs.push_back(mk(1, 12, 0, 16'h0,    0, 0, 0));
    vecs.push_back(mk(1, 11, 0, 16'h0,    0, 0, 0));
    vecs.push_back(mk(1, 1,  0, 16'h0,    1, 0, 0));
    vecs.push_back(mk(1, 10, 0, 16'h0,    0, 0, 0));
    vecs.push_back(mk(1, 1,  0, 16'h0,    1, 0, 0));
    vecs.push_back(mk(1, 2,  0, 16'h0,    2, 0, 0));
    vecs.push_back(mk(1, 11, 0, 16'h0,    2, 0, 0));
    vecs.push_back(mk(0, 0,  0, 16'h0,    0, 0, 1));
    vecs.push_back(mk(1, 1,  0, 16'h0,    1, 0, 0));
    vecs.push_back(mk(1, 2,  0, 16'h0,    2, 0, 0));
    vecs.push_back(mk(1, 3,  0, 16'h0,    3, 0, 0));
    vecs.push_back(mk(1, 4,  0, 16'h0,    4, 0, 0));
    vecs.push_back(mk(1, 5,  0, 16'h0,    4, 0, 0));
    vecs.push_back(mk(1, 11, 0, 16'h0,    4, 0, 0));
    vecs.push_back(mk(0, 0,  0, 16'h0,    0, 1, 0));
    vecs.push_back(mk(0, 0,  0, 16'h0,    0, 0, 0));
    vecs.push_back(mk(1, 3,  0, 16'h0,    1, 0, 0));
    vecs.push_back(mk(1, 7,  1, 16'h1234, 0, 0, 0));
    vecs.push_back(mk(1, 13, 0, 16'h0,    0, 0, 0));

    // reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_count", 32'(digit_count), 32'd0);
    chk("rst_unlock", 32'(unlock), 32'd0);
    chk("rst_fail", 32'(fail), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
`ifdef PIN_SHUFFLE_EN
    chk("rst_shuffle", 32'(shuffle_init), 32'd1);
`else
    chk("rst_shuffle", 32'(shuffle_init), 32'd0);
`endif
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      key_valid = vecs[i].kv;
      key_index = vecs[i].key;
      pw_load   = vecs[i].ld;
      pw_value  = vecs[i].pw;
      #1;
      chk($sformatf("v%0d_bidx", i), 32'(button_index), 32'(vecs[i].kv ? vecs[i].key : 4'd0));
      @(posedge clk); #1;
      key_valid = 1'b0; key_index = 4'd0; pw_load = 1'b0;
      chk($sformatf("v%0d_count", i), 32'(digit_count), 32'(vecs[i].cnt));
      chk($sformatf("v%0d_unlock", i), 32'(unlock), 32'(vecs[i].u));
      chk($sformatf("v%0d_fail", i), 32'(fail), 32'(vecs[i].f));
      chk($sformatf("v%0d_locked", i), 32'(locked), 32'd0);
`ifdef PIN_SHUFFLE_EN
      exp_sh = vecs[i].u | vecs[i].f;
`else
      exp_sh = 1'b0;
`endif
      chk($sformatf("v%0d_shuffle", i), 32'(shuffle_init), 32'(exp_sh));
    end

    // shuffled display: position 0 shows 7
    dmap[0] = 4'd7;
    press(4'd0);
    chk("map_entry_lsn", 32'(dut.entry[3:0]), 32'd7);
    chk("map_count", 32'(digit_count), 32'd1);
    press(KEY_CLEAR);
    chk("map_clear", 32'(digit_count), 32'd0);
    dmap[0] = 4'd0;

    // three wrong PINs -> lockout
    for (int t = 0; t < 3; t++) begin
      enter_pin(16'h9999);
      @(posedge clk); #1;
      chk($sformatf("wrong%0d_fail", t), 32'(fail), 32'd1);
      chk($sformatf("wrong%0d_locked", t), 32'(locked), 32'(t == 2));
    end
    n = 0;
    while (locked && n < 50) begin
      n++;
      key_valid = 1'b1; key_index = 4'd1;
      @(posedge clk); #1;
      key_valid = 1'b0; key_index = 4'd0;
      chk($sformatf("lock%0d_count", n), 32'(digit_count), 32'd0);
    end
    chk("lock_len", 32'(n), 32'd10);
    chk("lock_released", 32'(locked), 32'd0);
    enter_pin(16'h1234);
    @(posedge clk); #1;
    chk("post_lock_unlock", 32'(unlock), 32'd1);
    chk("post_lock_fail", 32'(fail), 32'd0);

    // reset mid-entry
    press(4'd1);
    press(4'd2);
    chk("pre_rst_count", 32'(digit_count), 32'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_count", 32'(digit_count), 32'd0);
    chk("mid_rst_state", 32'(dut.state), 32'(IDLE));
`ifdef PIN_SHUFFLE_EN
    chk("mid_rst_shuffle", 32'(shuffle_init), 32'd1);
`else
    chk("mid_rst_shuffle", 32'(shuffle_init), 32'd0);
`endif
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
